// File: rtl/uart_char_rx.sv
// 8N1 UART receiver that delivers LSB-first bytes with a valid strobe, a framing-error
// strobe and an ASCII-digit flag. Define UART_CHAR_RX_PARITY_EN to add an even-parity bit.
module uart_char_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rxd,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       char_is_digit,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_CHAR_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       char_q, char_d;
  logic             digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rxd_meta_q, rxd_s_q;
  logic             par_ok;

`ifdef UART_CHAR_RX_PARITY_EN
  logic par_ok_q, par_ok_d;
  assign par_ok = par_ok_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) par_ok_q <= 1'b1;
    else      par_ok_q <= par_ok_d;
  end
`else
  assign par_ok = 1'b1;
`endif

  // Synchronizer resets to the idle line level so release of clr never looks like a start bit.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    char_d    = char_q;
    digit_d   = digit_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_CHAR_RX_PARITY_EN
    par_ok_d  = par_ok_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          shift_d   = {rxd_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_CHAR_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_CHAR_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d    = '0;
          par_ok_d = (rxd_s_q == ^shift_q);
          state_d  = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rxd_s_q && par_ok) begin
            char_d  = shift_q;
            digit_d = (shift_q >= 8'h30) && (shift_q <= 8'h39);
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            // A low stop bit means the line may be held in break; wait for it to recover.
            state_d = rxd_s_q ? S_IDLE : S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      char_q    <= '0;
      digit_q   <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      char_q    <= char_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign char_out      = char_q;
  assign char_is_digit = digit_q;
  assign char_valid    = valid_q;
  assign frame_err     = ferr_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_char_rx.sv
// Scoreboard bench for uart_char_rx: stimulus pushes expected pulses, a monitor pops and compares.
module tb_uart_char_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] char_out;
  logic       char_valid, char_is_digit, frame_err, busy;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic       digit;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic [7:0] last_good = 8'h00;

  uart_char_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .clr(clr), .rxd(rxd),
    .char_out(char_out), .char_valid(char_valid), .char_is_digit(char_is_digit),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_CHAR_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    e.digit  = (d >= 8'h30) && (d <= 8'h39);
    sb_q.push_back(e);
    last_good = d;
    send_frame(d, 1'b1, 1'b0);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    e.digit  = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (clr && (char_valid || frame_err)) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pulse: valid=%0b ferr=%0b char=%0h at %0t",
                 char_valid, frame_err, char_out, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_is_err", 32'(frame_err), 32'(e.is_err));
        check("pulse_is_valid", 32'(char_valid), 32'(!e.is_err));
        check("char_out", 32'(char_out), 32'(e.data));
        if (!e.is_err) check("char_is_digit", 32'(char_is_digit), 32'(e.digit));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a toggling line.
    for (int i = 0; i < 20; i++) begin
      rxd = i[0];
      @(posedge clk);
      #1;
    end
    check("rst_char_out", 32'(char_out), 32'h00);
    check("rst_valid", 32'(char_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    idle(20);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_char", 32'(char_out), 32'h00);

    // Single byte, then back-to-back frames with no idle gap.
    send_good(8'h37);
    idle(10);
    send_good(8'h33);
    send_good(8'h2B);
    send_good(8'h35);
    idle(20);

    // Short glitch shorter than half a bit.
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(30);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_char", 32'(char_out), 32'h35);

    // Bad stop bit followed by a held-low line.
    push_err();
    send_frame(8'h41, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("break_busy", 32'(busy), 32'h1);
    check("break_char", 32'(char_out), 32'h35);
    idle(6);
    check("break_exit_busy", 32'(busy), 32'h0);
    send_good(8'h39);
    idle(10);

    // Digit-range boundaries.
    send_good(8'h2F);
    send_good(8'h30);
    send_good(8'h3A);
    idle(10);

    // Reset in the middle of a frame (after data bit 3 of 8'h38).
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h38 >> i));
    clr = 1'b0;
    #1;
    check("midrst_char", 32'(char_out), 32'h00);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_valid", 32'(char_valid), 32'h0);
    last_good = 8'h00;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    idle(20);
    send_good(8'h32);
    idle(10);

`ifdef UART_CHAR_RX_PARITY_EN
    push_err();
    send_frame(8'h31, 1'b1, 1'b1);
    idle(10);
    check("par_char", 32'(char_out), 32'h32);
`endif

    // Drain: all expected pulses must have appeared within a bounded time.
    for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_char_rx.md
Name: uart_char_rx

Overview:
- Serial-to-byte front end for the character recognizer stage.
- Receives an asynchronous 8N1 UART line (8 data bits, no parity, 1 stop bit) and assembles LSB-first bytes.
- Presents each good byte on a held 8-bit bus with a one-cycle valid strobe; the recognizer samples that bus.
- Also flags framing errors and classifies each delivered byte as an ASCII digit or not.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535; must be even.
- CNT_W, 16, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-low reset; all state clears while clr=0.
- rxd  input  1  serial line; idles high; asynchronous to clk.
- char_out  output  8  last correctly framed byte; held until the next good byte.
- char_valid  output  1  one-cycle pulse; char_out was updated on this edge.
- char_is_digit  output  1  registered with char_out; 1 iff char_out is in "0".."9" (8'h30..8'h39).
- frame_err  output  1  one-cycle pulse; stop bit (or parity, if enabled) was bad.
- busy  output  1  1 whenever the state is not IDLE.

Behaviour:
- Reset (clr=0, async): state=IDLE; counter=0; bit index=0; shift register=0; synchronizer flops=1.
- Output reset values: char_out=8'h00, char_is_digit=0, char_valid=0, frame_err=0, busy=0.
- Input sync: rxd passes through 2 flops (rxd_s) before any use. All timing below refers to rxd_s.
- IDLE: when rxd_s=0, go to START with counter=0.
- START: counter increments each cycle. At counter=CLKS_PER_BIT/2-1, sample rxd_s:
  - rxd_s=0: valid start bit; go to DATA, counter=0, bit index=0.
  - rxd_s=1: glitch; go to IDLE, no outputs.
- DATA: sample rxd_s at counter=CLKS_PER_BIT-1 (the mid-bit point).
  - Shift the sample into the MSB and shift right, so the byte assembles LSB first.
  - Counter returns to 0.
  - After bit index 7, go to STOP (or PARITY when the optional feature is enabled).
- STOP: sample at counter=CLKS_PER_BIT-1.
  - rxd_s=1: char_out<=shift, char_is_digit updated, char_valid=1 for exactly one cycle; go to IDLE.
  - rxd_s=0: frame_err=1 for one cycle; char_out unchanged; go to BREAK.
- BREAK: wait until rxd_s=1, then go to IDLE. A held-low line therefore produces exactly one frame_err and no spurious frames.
- char_valid and frame_err are never asserted on the same cycle.
- Back-to-back frames: IDLE is re-entered in the cycle after the stop sample, so a start edge half a bit later is caught.
- Latency: char_valid rises at most 3 clk cycles after the mid-stop-bit instant on rxd (2 sync flops plus 1 register).
- clr low mid-frame: the partial byte is discarded, char_out returns to 8'h00, and no pulse is issued.
- Counter arithmetic: unsigned CNT_W bits; it never exceeds CLKS_PER_BIT-1, so no wrap occurs.

Optional Feature:
- Macro: UART_CHAR_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows the data bits and is sampled in a PARITY state at counter=CLKS_PER_BIT-1.
  - The result is stored and checked at STOP.
  - Parity mismatch with a good stop bit: frame_err pulses, char_out is unchanged, next state is IDLE.
  - Frame length is 11 bits.
- Undefined: no PARITY state exists; frame length is 10 bits; behaviour is exactly as above.

Test Plan:
- Reset: hold clr=0 with rxd toggling -> char_out=8'h00, all pulses 0, busy=0. Release clr -> outputs stay idle while rxd=1.
- Single byte: CLKS_PER_BIT=16, send 8'h37 ("7") -> one char_valid pulse, char_out=8'h37, char_is_digit=1, frame_err=0.
- Back-to-back: send "3", "+", "5" with no idle gap -> three char_valid pulses with char_out 8'h33, 8'h2B, 8'h35 and char_is_digit 1, 0, 1.
- Glitch: pull rxd low for 5 cycles (less than CLKS_PER_BIT/2) -> returns to IDLE, no pulses, char_out unchanged.
- Break/frame error: send 8'h41 with the stop bit low, then hold rxd low for 40 cycles -> exactly one frame_err pulse, char_out keeps its previous value, busy=1 until rxd returns high. A following 8'h39 is received correctly.
- Reset mid-frame: assert clr after bit 3 of 8'h38 -> no pulse, char_out=8'h00. The next complete frame 8'h32 is received correctly.
- With UART_CHAR_RX_PARITY_EN defined: send 8'h31 with a wrong parity bit -> frame_err pulse, no char_valid.
